// File: rtl/button_event_latch.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_latch
//  Purpose  : Synchronizes and debounces the five per-key level flags from
//             the keycode decoder. Rising and falling edges of the accepted
//             levels are collected between frame boundaries. One clean event
//             vector is presented per video frame.
//  Ports    : Clk         - system clock
//             Reset       - asynchronous, active-high reset
//             frame_clk   - vsync-derived strobe; rising edge = frame boundary
//             pone_dive, pone_kick, ptwo_dive, ptwo_kick, game_start
//                         - decoder level flags (asynchronous to Clk)
//             btn_held    - debounced accepted levels
//             btn_press   - rising edges of btn_held in last completed frame
//             btn_release - falling edges of btn_held in last completed frame
//             frame_valid - one-cycle pulse when press/release are updated
//  Bit order: [0] pone_dive [1] pone_kick [2] ptwo_dive [3] ptwo_kick
//             [4] game_start
//  Revision : 1.0 - initial release
// ============================================================================
module button_event_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       pone_dive,
    input  logic       pone_kick,
    input  logic       ptwo_dive,
    input  logic       ptwo_kick,
    input  logic       game_start,
    output logic [4:0] btn_held,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic       frame_valid
);

    localparam int             c_NUM_BTN = 5;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_NUM_BTN-1:0] w_btn_raw;
    logic [c_NUM_BTN-1:0] r_btn_s1;
    logic [c_NUM_BTN-1:0] r_btn_s2;
    logic                 r_fc_s1;
    logic                 r_fc_s2;
    logic                 r_fc_d;
    logic                 w_tick;
    logic [c_NUM_BTN-1:0] w_accept;
    logic [c_NUM_BTN-1:0] w_rise;
    logic [c_NUM_BTN-1:0] w_fall;
    logic [c_NUM_BTN-1:0] r_pend_press;
    logic [c_NUM_BTN-1:0] r_pend_release;

    assign w_btn_raw = {game_start, ptwo_kick, ptwo_dive, pone_kick, pone_dive};

    // Two-flop synchronizers. The frame_clk chain resets high so that a
    // strobe already high when reset is released is not seen as an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_fc_s1  <= 1'b1;
            r_fc_s2  <= 1'b1;
            r_fc_d   <= 1'b1;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_fc_s1  <= frame_clk;
            r_fc_s2  <= r_fc_s1;
            r_fc_d   <= r_fc_s2;
        end
    end

    assign w_tick = r_fc_s2 & ~r_fc_d;

    // Per-button debounce counter. w_accept marks the cycle in which the
    // synced level has disagreed with btn_held for DEBOUNCE_CYCLES cycles;
    // btn_held flips at the following edge.
    generate
        for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
            logic [CNT_W-1:0] r_cnt;
            logic             w_diff;

            assign w_diff       = r_btn_s2[gi] ^ btn_held[gi];
            assign w_accept[gi] = w_diff && (r_cnt == c_CNT_MAX);

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_cnt <= '0;
                end else if (!w_diff || w_accept[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    // Edges are flagged in the cycle before btn_held changes, so an edge
    // coinciding with the tick lands in the same report as the new level.
    assign w_rise = w_accept &  r_btn_s2;
    assign w_fall = w_accept & ~r_btn_s2;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            btn_held       <= '0;
            btn_press      <= '0;
            btn_release    <= '0;
            frame_valid    <= 1'b0;
            r_pend_press   <= '0;
            r_pend_release <= '0;
        end else begin
            btn_held    <= btn_held ^ w_accept;
            frame_valid <= w_tick;
            if (w_tick) begin
                btn_press      <= r_pend_press   | w_rise;
                btn_release    <= r_pend_release | w_fall;
                r_pend_press   <= '0;
                r_pend_release <= '0;
            end else begin
                r_pend_press   <= r_pend_press   | w_rise;
                r_pend_release <= r_pend_release | w_fall;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_latch
//  Purpose  : Self-checking bench for button_event_latch (DEBOUNCE_CYCLES=4).
//             Table of per-frame scenarios plus hand-written sequences for
//             reset, latency, tick-coincident edges and mid-frame reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_latch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [4:0] btn;
    logic [4:0] btn_held;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       frame_valid;

    int checks = 0;
    int errors = 0;

    button_event_latch #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .pone_dive  (btn[0]),
        .pone_kick  (btn[1]),
        .ptwo_dive  (btn[2]),
        .ptwo_kick  (btn[3]),
        .game_start (btn[4]),
        .btn_held   (btn_held),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .frame_valid(frame_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0] a;
        int         na;
        logic [4:0] b;
        int         nb;
        logic [4:0] eh;
        logic [4:0] ep;
        logic [4:0] er;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Raise frame_clk, wait (bounded) for frame_valid, check the report and
    // that the pulse is one cycle wide with the report held afterwards.
    task automatic frame(input string name, input logic [4:0] eh,
                         input logic [4:0] ep, input logic [4:0] er);
        bit found;
        found = 0;
        frame_clk = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (frame_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_timeout: got frame_valid 0 expected 1 within 12 cycles", name);
        end else begin
            chk({name, "_held"},    btn_held,    eh);
            chk({name, "_press"},   btn_press,   ep);
            chk({name, "_release"}, btn_release, er);
            cyc(1);
            chk({name, "_fv_pulse"}, {4'b0, frame_valid}, 5'b0);
            chk({name, "_press_hold"}, btn_press, ep);
        end
        frame_clk = 1'b0;
        cyc(2);
    endtask

    initial begin
        bit fv_seen;
        //        a         na  b         nb  held      press     release
        tbl[0] = '{5'b00010, 10, 5'b00010, 10, 5'b00010, 5'b00010, 5'b00000};
        tbl[1] = '{5'b00010, 10, 5'b00010, 10, 5'b00010, 5'b00000, 5'b00000};
        tbl[2] = '{5'b00110,  3, 5'b00010, 10, 5'b00010, 5'b00000, 5'b00000};
        tbl[3] = '{5'b00110,  4, 5'b00010, 10, 5'b00010, 5'b00100, 5'b00100};
        tbl[4] = '{5'b10010, 10, 5'b00010, 10, 5'b00010, 5'b10000, 5'b10000};
        tbl[5] = '{5'b00000, 10, 5'b00000, 10, 5'b00000, 5'b00000, 5'b00010};
        tbl[6] = '{5'b01111, 10, 5'b01111, 10, 5'b01111, 5'b01111, 5'b00000};
        tbl[7] = '{5'b00101, 10, 5'b00101, 10, 5'b00101, 5'b00000, 5'b01010};
        tbl[8] = '{5'b00000, 10, 5'b00000, 10, 5'b00000, 5'b00000, 5'b00101};

        // Reset released with frame_clk already high: no tick, outputs 0.
        Reset     = 1'b1;
        frame_clk = 1'b1;
        btn       = '0;
        cyc(3);
        Reset   = 1'b0;
        fv_seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (frame_valid) fv_seen = 1;
        end
        chk("rst_no_tick",  {4'b0, fv_seen}, 5'b0);
        chk("rst_held",     btn_held,    5'b0);
        chk("rst_press",    btn_press,   5'b0);
        chk("rst_release",  btn_release, 5'b0);
        frame_clk = 1'b0;
        cyc(3);

        // Debounce latency: first sampled at E0, visible after E5.
        btn = 5'b00010;
        cyc(5);
        chk("lat_after_E4", btn_held, 5'b00000);
        cyc(1);
        chk("lat_after_E5", btn_held, 5'b00010);

        for (int i = 0; i < 9; i++) begin
            btn = tbl[i].a;
            cyc(tbl[i].na);
            btn = tbl[i].b;
            cyc(tbl[i].nb);
            frame($sformatf("vec%0d", i), tbl[i].eh, tbl[i].ep, tbl[i].er);
        end

        // pone_dive accepted at the same edge that registers the tick.
        btn = 5'b00001;
        cyc(3);
        frame_clk = 1'b1;
        cyc(2);
        chk("coinc_pre_fv",   {4'b0, frame_valid}, 5'b0);
        chk("coinc_pre_held", btn_held, 5'b0);
        cyc(1);
        chk("coinc_fv",    {4'b0, frame_valid}, 5'b1);
        chk("coinc_held",  btn_held,  5'b00001);
        chk("coinc_press", btn_press, 5'b00001);
        cyc(1);
        chk("coinc_fv_pulse", {4'b0, frame_valid}, 5'b0);
        frame_clk = 1'b0;
        cyc(3);
        frame("coinc_next", 5'b00001, 5'b00000, 5'b00000);

        // All player keys pressed, reset mid-frame before the tick.
        btn = 5'b01111;
        cyc(10);
        Reset = 1'b1;
        #1;
        chk("mrst_held",    btn_held,    5'b0);
        chk("mrst_press",   btn_press,   5'b0);
        chk("mrst_release", btn_release, 5'b0);
        chk("mrst_fv",      {4'b0, frame_valid}, 5'b0);
        cyc(1);
        Reset = 1'b0;
        cyc(12);
        frame("post_reset", 5'b01111, 5'b01111, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
